// File: rtl/dpll_rst_seq_if.sv
// Lock/reset handshake between the DPLL reset sequencer and its surroundings.
// The master side is the sequencer itself; the slave side drives lock and software requests.
interface dpll_rst_seq_if #(
    parameter int STAGES = 3
);
    logic              lock_in;
    logic              rst_req;
    logic [STAGES-1:0] stage_rst_n;
    logic              ready;
    logic [7:0]        relock_cnt;

    modport master (
        input  lock_in,
        input  rst_req,
        output stage_rst_n,
        output ready,
        output relock_cnt
    );

    modport slave (
        output lock_in,
        output rst_req,
        input  stage_rst_n,
        input  ready,
        input  relock_cnt
    );
endinterface

// File: rtl/dpll_rst_seq.sv
// Filters DPLL lock and releases downstream active-low resets in order, GAP cycles apart.
// Any raw lock drop or software request while sequencing or running slams every stage back into reset.
module dpll_rst_seq #(
    parameter int STAGES    = 3,
    parameter int GAP       = 16,
    parameter int LOCK_FILT = 8
) (
    input  logic           clk,
    input  logic           rst,
    dpll_rst_seq_if.master bus
);
    localparam int FW = $clog2(LOCK_FILT) + 1;
    localparam int GW = $clog2(GAP) + 1;
    localparam int IW = $clog2(STAGES) + 1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [FW-1:0]     filt_q, filt_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [STAGES-1:0] stage_q, stage_d;
    logic              ready_q, ready_d;
    logic [7:0]        relock_q, relock_d;

    logic              lock_ok_s;
    logic              abort_s;
    logic [GW-1:0]     gap_inc_s;

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WAIT_LOCK;
            filt_q   <= '0;
            gap_q    <= '0;
            idx_q    <= '0;
            stage_q  <= '0;
            ready_q  <= 1'b0;
            relock_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            filt_q   <= filt_d;
            gap_q    <= gap_d;
            idx_q    <= idx_d;
            stage_q  <= stage_d;
            ready_q  <= ready_d;
            relock_q <= relock_d;
        end
    end

    // Next-state logic: lock filter, release sequencing and abort handling.
    always_comb begin
        state_d   = state_q;
        filt_d    = filt_q;
        gap_d     = gap_q;
        idx_d     = idx_q;
        stage_d   = stage_q;
        ready_d   = ready_q;
        relock_d  = relock_q;
        lock_ok_s = (filt_q == FW'(LOCK_FILT));
        gap_inc_s = gap_q + GW'(1);
        abort_s   = ((state_q == RELEASE) || (state_q == RUN)) &&
                    (!bus.lock_in || bus.rst_req);

        if ((state_q == HOLD) || bus.rst_req || !bus.lock_in) begin
            filt_d = '0;
        end else if (!lock_ok_s) begin
            filt_d = filt_q + FW'(1);
        end else begin
            filt_d = filt_q;
        end

        case (state_q)
            WAIT_LOCK: begin
                if (lock_ok_s && !bus.rst_req) begin
                    state_d = RELEASE;
                    stage_d = STAGES'(1);
                    gap_d   = '0;
                    idx_d   = '0;
                end else begin
                    stage_d = '0;
                    ready_d = 1'b0;
                end
            end
            RELEASE, RUN: begin
                if (abort_s) begin
                    state_d = HOLD;
                    stage_d = '0;
                    ready_d = 1'b0;
                    gap_d   = '0;
                    idx_d   = '0;
                    // Only a genuine lock loss out of RUN counts as a relock event.
                    if ((state_q == RUN) && !bus.lock_in && (relock_q != 8'd255)) begin
                        relock_d = relock_q + 8'd1;
                    end else begin
                        relock_d = relock_q;
                    end
                end else if (state_q == RUN) begin
                    ready_d = 1'b1;
                end else if (gap_inc_s == GW'(GAP)) begin
                    gap_d = '0;
                    if (idx_q == IW'(STAGES - 1)) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        stage_d = stage_q | (STAGES'(1) << (idx_q + IW'(1)));
                    end
                end else begin
                    gap_d = gap_inc_s;
                end
            end
            HOLD: begin
                if (gap_inc_s == GW'(GAP)) begin
                    gap_d   = '0;
                    state_d = WAIT_LOCK;
                end else begin
                    gap_d = gap_inc_s;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                filt_d  = '0;
                gap_d   = '0;
                idx_d   = '0;
                stage_d = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign bus.stage_rst_n = stage_q;
    assign bus.ready       = ready_q;
    assign bus.relock_cnt  = relock_q;
endmodule

// File: tb/tb_dpll_rst_seq.sv
// Randomised and directed bench for dpll_rst_seq against a timing-rule model of the sequencer.
module tb_dpll_rst_seq;
    localparam int STAGES    = 3;
    localparam int GAP       = 16;
    localparam int LOCK_FILT = 8;
    localparam int RUN_T     = STAGES * GAP;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Model: "active" means stage 0 is released; m_t counts edges since that release.
    bit   m_active;
    int   m_t;
    int   m_hold;
    int   m_streak;
    int   m_relock;

    dpll_rst_seq_if #(.STAGES(STAGES)) bus ();

    dpll_rst_seq #(
        .STAGES   (STAGES),
        .GAP      (GAP),
        .LOCK_FILT(LOCK_FILT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [STAGES-1:0] exp_stage();
        logic [STAGES-1:0] v;
        int n;
        v = '0;
        if (m_active) begin
            n = m_t / GAP + 1;
            if (n > STAGES) n = STAGES;
            for (int i = 0; i < STAGES; i++) begin
                if (i < n) v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic exp_ready();
        return m_active && (m_t >= RUN_T);
    endfunction

    task automatic model_edge(input bit r, input bit l, input bit q);
        if (r) begin
            m_active = 0; m_t = 0; m_hold = 0; m_streak = 0; m_relock = 0;
        end else if (m_active && (!l || q)) begin
            if ((m_t >= RUN_T) && !l && (m_relock < 255)) m_relock++;
            m_active = 0; m_t = 0; m_hold = GAP; m_streak = 0;
        end else if (m_active) begin
            if (m_t < RUN_T) m_t++;
        end else if (m_hold > 0) begin
            m_hold--;
            m_streak = 0;
        end else begin
            if ((m_streak >= LOCK_FILT) && !q) begin
                m_active = 1; m_t = 0;
            end
            if (!l || q) m_streak = 0;
            else if (m_streak < LOCK_FILT) m_streak++;
        end
    endtask

    task automatic cycle(input bit r, input bit l, input bit q);
        rst = r;
        bus.lock_in = l;
        bus.rst_req = q;
        @(posedge clk);
        model_edge(r, l, q);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.stage_rst_n !== 3'b000 || bus.ready !== 1'b0 || bus.relock_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset stage=%b ready=%b relock=%0d expected 000/0/0",
                     bus.stage_rst_n, bus.ready, bus.relock_cnt);
        end
    endtask

    task automatic test_nominal();
        for (int n = 0; n < 100; n++) begin
            cycle(1'b0, 1'b1, 1'b0);
            checks++;
            if (bus.stage_rst_n !== exp_stage() || bus.ready !== exp_ready() ||
                bus.relock_cnt !== 8'(m_relock)) begin
                failures++;
                $display("FAIL nominal_model edge=%0d got %b/%b/%0d expected %b/%b/%0d", n,
                         bus.stage_rst_n, bus.ready, bus.relock_cnt, exp_stage(), exp_ready(), m_relock);
            end
            if (n == 7 || n == 8 || n == 24 || n == 40 || n == 55 || n == 56) begin
                logic [STAGES-1:0] es;
                logic er;
                es = (n == 7) ? 3'b000 : (n == 8) ? 3'b001 : (n == 24) ? 3'b011 : 3'b111;
                er = (n == 56);
                checks++;
                if (bus.stage_rst_n !== es || bus.ready !== er || bus.relock_cnt !== 8'd0) begin
                    failures++;
                    $display("FAIL nominal_timing edge=%0d got %b/%b expected %b/%b", n,
                             bus.stage_rst_n, bus.ready, es, er);
                end
            end
        end
    endtask

    task automatic test_lock_loss();
        for (int e = 100; e <= 130; e++) begin
            cycle(1'b0, (e != 100), 1'b0);
            checks++;
            if (bus.stage_rst_n !== exp_stage() || bus.ready !== exp_ready() ||
                bus.relock_cnt !== 8'(m_relock)) begin
                failures++;
                $display("FAIL lockloss_model edge=%0d got %b/%b/%0d expected %b/%b/%0d", e,
                         bus.stage_rst_n, bus.ready, bus.relock_cnt, exp_stage(), exp_ready(), m_relock);
            end
            if (e == 100) begin
                checks++;
                if (bus.stage_rst_n !== 3'b000 || bus.ready !== 1'b0 || bus.relock_cnt !== 8'd1) begin
                    failures++;
                    $display("FAIL lockloss_abort got %b/%b/%0d expected 000/0/1",
                             bus.stage_rst_n, bus.ready, bus.relock_cnt);
                end
            end else if (e == 124 || e == 125) begin
                checks++;
                if (bus.stage_rst_n[0] !== (e == 125)) begin
                    failures++;
                    $display("FAIL lockloss_rerelease edge=%0d stage0=%b expected %b", e,
                             bus.stage_rst_n[0], (e == 125));
                end
            end
        end
    endtask

    task automatic test_abort_release();
        int w;
        w = 0;
        while (exp_stage() != 3'b011 && w < 100) begin
            cycle(1'b0, 1'b1, 1'b0);
            w++;
        end
        checks++;
        if (w >= 100) begin
            failures++;
            $display("FAIL abort_release_timeout waited=%0d expected stage 011", w);
        end
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.stage_rst_n !== 3'b000 || bus.ready !== 1'b0 || bus.relock_cnt !== 8'd1) begin
            failures++;
            $display("FAIL abort_release got %b/%b/%0d expected 000/0/1",
                     bus.stage_rst_n, bus.ready, bus.relock_cnt);
        end
        for (int k = 1; k <= 45; k++) begin
            cycle(1'b0, 1'b1, 1'b0);
            checks++;
            if (bus.stage_rst_n !== exp_stage() || bus.relock_cnt !== 8'(m_relock)) begin
                failures++;
                $display("FAIL abort_restart_model k=%0d got %b/%0d expected %b/%0d", k,
                         bus.stage_rst_n, bus.relock_cnt, exp_stage(), m_relock);
            end
            if (k == 24 || k == 25 || k == 41) begin
                logic [STAGES-1:0] es;
                es = (k == 24) ? 3'b000 : (k == 25) ? 3'b001 : 3'b011;
                checks++;
                if (bus.stage_rst_n !== es) begin
                    failures++;
                    $display("FAIL abort_restart_timing k=%0d got %b expected %b", k, bus.stage_rst_n, es);
                end
            end
        end
    endtask

    task automatic test_glitch();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        for (int j = 0; j <= 30; j++) begin
            cycle(1'b0, (j != 7), 1'b0);
            checks++;
            if (bus.stage_rst_n !== exp_stage() || bus.ready !== exp_ready()) begin
                failures++;
                $display("FAIL glitch_model j=%0d got %b/%b expected %b/%b", j,
                         bus.stage_rst_n, bus.ready, exp_stage(), exp_ready());
            end
            if (j < 16 || j == 16) begin
                logic [STAGES-1:0] es;
                es = (j == 16) ? 3'b001 : 3'b000;
                checks++;
                if (bus.stage_rst_n !== es) begin
                    failures++;
                    $display("FAIL glitch_timing j=%0d got %b expected %b", j, bus.stage_rst_n, es);
                end
            end
        end
    endtask

    task automatic test_sync_reset();
        cycle(1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 20; j++) cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.stage_rst_n !== 3'b001) begin
            failures++;
            $display("FAIL syncrst_setup got %b expected 001", bus.stage_rst_n);
        end
        cycle(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.stage_rst_n !== 3'b000 || bus.ready !== 1'b0 || bus.relock_cnt !== 8'd0) begin
            failures++;
            $display("FAIL syncrst got %b/%b/%0d expected 000/0/0",
                     bus.stage_rst_n, bus.ready, bus.relock_cnt);
        end
        for (int k = 0; k <= 8; k++) begin
            cycle(1'b0, 1'b1, 1'b0);
            checks++;
            if (bus.stage_rst_n !== ((k == 8) ? 3'b001 : 3'b000)) begin
                failures++;
                $display("FAIL syncrst_relaunch k=%0d got %b expected %b", k, bus.stage_rst_n,
                         ((k == 8) ? 3'b001 : 3'b000));
            end
        end
    endtask

    task automatic test_saturation();
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) begin
            int w;
            int er;
            w = 0;
            while (!exp_ready() && w < 200) begin
                cycle(1'b0, 1'b1, 1'b0);
                w++;
            end
            checks++;
            if (w >= 200 || bus.ready !== 1'b1) begin
                failures++;
                $display("FAIL sat_reach_run iter=%0d ready=%b waited=%0d expected ready 1", i, bus.ready, w);
            end
            cycle(1'b0, 1'b0, 1'b0);
            er = (i + 1 > 255) ? 255 : i + 1;
            checks++;
            if (bus.relock_cnt !== 8'(er) || bus.ready !== 1'b0 || bus.stage_rst_n !== 3'b000) begin
                failures++;
                $display("FAIL sat_count iter=%0d got %0d/%b/%b expected %0d/0/000", i,
                         bus.relock_cnt, bus.ready, bus.stage_rst_n, er);
            end
        end
    endtask

    task automatic test_random();
        int rate;
        for (int b = 0; b < 20; b++) begin
            case ($urandom_range(0, 2))
                0:       rate = 3;
                1:       rate = 30;
                default: rate = 400;
            endcase
            for (int c = 0; c < 200; c++) begin
                bit r, l, q;
                r = ($urandom_range(0, 499) == 0);
                l = ($urandom_range(0, rate - 1) != 0);
                q = ($urandom_range(0, 149) == 0);
                cycle(r, l, q);
                checks++;
                if (bus.stage_rst_n !== exp_stage() || bus.ready !== exp_ready() ||
                    bus.relock_cnt !== 8'(m_relock)) begin
                    failures++;
                    $display("FAIL random b=%0d c=%0d got %b/%b/%0d expected %b/%b/%0d", b, c,
                             bus.stage_rst_n, bus.ready, bus.relock_cnt, exp_stage(), exp_ready(), m_relock);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.lock_in = 1'b0;
        bus.rst_req = 1'b0;
        model_edge(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_nominal();
        test_lock_loss();
        test_abort_release();
        test_glitch();
        test_sync_reset();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dpll_rst_seq.md
# dpll_rst_seq

Reset sequencer that consumes the DPLL lock indication and releases downstream reset domains in order. It filters `lock_in`, then deasserts `STAGES` active-low stage resets one at a time, spaced `GAP` cycles apart, and flags `ready` once all stages are out of reset. It re-asserts every stage reset immediately on loss of lock or on a software request. It sits between the DPLL core and the loop filter, NCO and output logic, and drives their `rst_n` inputs.

## Interface
- `STAGES`, 3: number of sequenced reset outputs, ≥1.
- `GAP`, 16: cycles between consecutive stage releases, and minimum hold time after an abort, ≥1.
- `LOCK_FILT`, 8: consecutive high `lock_in` samples required before release starts, ≥1.

- `clk` input 1: single system clock.
- `rst` input 1: reset, synchronous and active-high; highest priority.
- `lock_in` input 1: raw DPLL lock flag, synchronous to `clk`.
- `rst_req` input 1: software re-sequence request, level-sensitive.
- `stage_rst_n` output `STAGES`: per-domain active-low resets; bit 0 is released first.
- `ready` output 1: high while all stages are released (state RUN).
- `relock_cnt` output 8: saturating count of lock losses while in RUN.

## Operation
- States:
  - WAIT_LOCK: all stages held; filter counting.
  - RELEASE: stages deasserting in sequence.
  - RUN: all stages released.
  - HOLD: post-abort hold.
- Reset (`rst`=1 at an edge):
  - state=WAIT_LOCK, `stage_rst_n`=all 0, `ready`=0, `relock_cnt`=0.
  - Lock filter counter=0, gap counter=0, stage index=0.
- Lock filter:
  - `filt_cnt` clears on any `lock_in`=0 sample.
  - Otherwise it increments, saturating at `LOCK_FILT`.
  - It is forced to 0 in HOLD and while `rst_req`=1.
  - `lock_ok` ≡ (`filt_cnt`==`LOCK_FILT`).
- WAIT_LOCK → RELEASE when `lock_ok` and `rst_req`=0.
  - On that edge `stage_rst_n[0]`←1 and the gap counter clears.
- RELEASE:
  - The gap counter counts 1..`GAP`.
  - On reaching `GAP` it clears, and the next stage bit is set; bits already set stay set.
  - `GAP` cycles after the last stage bit is set, the block moves to RUN and sets `ready`←1.
- RUN: holds all ones; `ready`=1.
- Abort (in RELEASE or RUN, on a `lock_in`=0 sample or `rst_req`=1):
  - Same edge: `stage_rst_n`←0, `ready`←0, gap counter cleared, state→HOLD.
  - `lock_in` abort is raw and unfiltered.
- `relock_cnt` increments by 1 on an abort taken from RUN with `lock_in`=0, including when `rst_req` is also 1. It saturates at 255.
- HOLD:
  - Outputs stay held for `GAP` cycles, then the state goes to WAIT_LOCK.
  - `lock_in` and `rst_req` are ignored except through the filter clear.
- `rst_req` in WAIT_LOCK only keeps the filter cleared.
- Priority: `rst` > abort > sequencing.
- The stage index and counters are sized $clog2 of their parameter +1; no wrap is permitted.

## Timing
- All outputs are registered; none is combinational from inputs.
- Release timing, with `lock_in` first sampled high at edge k and held high:
  - `stage_rst_n[0]` rises after edge k+`LOCK_FILT`.
  - `stage_rst_n[i]` rises after edge k+`LOCK_FILT`+i·`GAP`.
  - `ready` rises after edge k+`LOCK_FILT`+`STAGES`·`GAP`.
- Abort latency: 1 edge. `lock_in`=0 sampled at edge a drives all stages low after edge a.
- Earliest re-release after an abort at edge a: `stage_rst_n[0]` rises after edge a+`GAP`+`LOCK_FILT`+1, assuming lock is continuous from edge a+`GAP`+1.
- Stage bits are monotonic during RELEASE: no bit falls except on an abort or `rst`.
- `rst` mid-RELEASE or mid-HOLD: the next edge yields the full reset values; `relock_cnt` clears.

## Test plan
- Nominal release: defaults, `rst` high for 4 cycles, then `lock_in`=1 from edge 0 → `stage_rst_n` goes 001 after edge 8, 011 after 24, 111 after 40; `ready`=1 after 56; `relock_cnt`=0.
- Glitch rejection: `lock_in` high 7 cycles, low 1, then high → release starts 8 edges after the second rise; no stage toggles before then.
- Lock loss in RUN: drop `lock_in` for 1 cycle at edge 100 → all stages 0 and `ready`=0 after edge 100; `relock_cnt`=1; stage 0 rises no earlier than after edge 125.
- Abort mid-RELEASE: `rst_req`=1 for 1 cycle while `stage_rst_n`=011 → 000 next edge; `relock_cnt` unchanged; the full sequence restarts from stage 0 after HOLD plus the filter delay.
- Saturation: 260 lock-loss aborts from RUN → `relock_cnt`=255 and it stays 255.
- Sync reset mid-operation: assert `rst` for 1 cycle during RELEASE with `rst_req`=1 and `lock_in`=0 → after that edge all outputs are 0 and the state is WAIT_LOCK; `rst` overrides both.
